irq_timer_ctrl: RTL and testbench

Parametrised interrupt and timer subsystem for the RISC_V core; successor to the fixed single-timer / single-external-line interrupt encoding.
- Hosts N_TIMERS programmable compare timers and N_EXT edge-detected external interrupt lines.
- Holds per-source sticky pending and mask bits.
- Presents the highest-priority enabled pending source to the core's CSR/trap logic as a cause code, with a valid/ack handshake.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_timer_ch.sv | 40 ++++
 rtl/irq_timer_ctrl.sv | 116 +++++++++++
 tb/tb_irq_timer_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, cause mapping and config address decode for irq_timer_ctrl
package irq_pkg;

  localparam int CAUSE_NONE = 0;

  typedef enum logic [1:0] {
    CFG_CMP    = 2'd0,
    CFG_MASK   = 2'd1,
    CFG_IGNORE = 2'd2
  } cfg_sel_e;

  // Source index to cause code; cause 0 is reserved for "nothing pending"
  function automatic int cause_of(input int src_index);
    return src_index + 1;
  endfunction

  // Addresses below n_timers hit a compare register, n_timers hits the mask, above is dropped
  function automatic cfg_sel_e cfg_decode(input int addr, input int n_timers);
    if (addr < n_timers) return CFG_CMP;
    else if (addr == n_timers) return CFG_MASK;
    else return CFG_IGNORE;
  endfunction

endpackage

// File: rtl/irq_timer_ch.sv
// rtl/irq_timer_ch.sv - one compare timer channel: counter, compare register and match pulse
module irq_timer_ch #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cmp_wr,
  input  logic [TIMER_W-1:0] cmp_data,
  output logic               ovf
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] cmp;

  // Compare register; a write lands at this edge so the new value is used from the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmp <= '1;
    else if (cmp_wr) cmp <= cmp_data;
  end

  // Free-running counter; a cmp below count lets it wrap through all-ones silently before matching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (count == cmp) begin
        count <= '0;
        ovf   <= 1'b1;
      end else begin
        count <= count + 1'b1;
        ovf   <= 1'b0;
      end
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_timer_ctrl.sv
// rtl/irq_timer_ctrl.sv - timers + edge-detected external lines, sticky pending/mask, priority cause encode; optional IRQ_EXT_SYNC_EN
module irq_timer_ctrl
  import irq_pkg::*;
#(
  parameter int N_TIMERS = 2,
  parameter int TIMER_W  = 16,
  parameter int N_EXT    = 2,
  parameter int CAUSE_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_TIMERS-1:0]             timer_en,
  input  logic [N_EXT-1:0]                ext_inter,
  input  logic                            cfg_wr,
  input  logic [$clog2(N_TIMERS+1)-1:0]   cfg_addr,
  input  logic [31:0]                     cfg_data,
  input  logic                            irq_ack,
  output logic                            irq_valid,
  output logic [CAUSE_W-1:0]              interrupt,
  output logic [N_TIMERS-1:0]             timer_ovf
);

  localparam int N_SRC = N_TIMERS + N_EXT;
  localparam int AW    = $clog2(N_TIMERS + 1);

  cfg_sel_e         cfg_sel;
  logic [N_EXT-1:0] ext_in;
  logic [N_EXT-1:0] ext_hist;
  logic [N_EXT-1:0] ext_edge;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] set_bits;
  logic [N_SRC-1:0] clr_bits;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data;

  // Classify the configuration address once for all register writes
  always_comb begin
    cfg_sel = cfg_decode(int'(cfg_addr), N_TIMERS);
  end

  genvar i;
  generate
    for (i = 0; i < N_TIMERS; i++) begin : g_timer
      irq_timer_ch #(.TIMER_W(TIMER_W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (timer_en[i]),
        .cmp_wr   (cfg_wr && (cfg_sel == CFG_CMP) && (cfg_addr == AW'(i))),
        .cmp_data (cfg_data[TIMER_W-1:0]),
        .ovf      (timer_ovf[i])
      );
    end
  endgenerate

`ifdef IRQ_EXT_SYNC_EN
  logic [N_EXT-1:0] sync_q1;
  logic [N_EXT-1:0] sync_q2;

  // Two-flop synchroniser for asynchronous external lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ext_inter;
      sync_q2 <= sync_q1;
    end
  end
  assign ext_in = sync_q2;
`else
  assign ext_in = ext_inter;
`endif

  // History resets low so a line already high at reset release counts as one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext_hist <= '0;
    else ext_hist <= ext_in;
  end

  assign ext_edge = ext_in & ~ext_hist;
  assign set_bits = {ext_edge, timer_ovf};
  assign active   = pending & mask;

  // Mask register; writes never touch pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask <= '1;
    else if (cfg_wr && (cfg_sel == CFG_MASK)) mask <= cfg_data[N_SRC-1:0];
  end

  // Lowest enabled pending index wins, so scan downward and let later hits override
  always_comb begin
    irq_valid = |active;
    interrupt = CAUSE_W'(CAUSE_NONE);
    for (int s = N_SRC - 1; s >= 0; s--) begin
      if (active[s]) interrupt = CAUSE_W'(cause_of(s));
    end
  end

  // Ack clears only the presented source, and only while something is presented
  always_comb begin
    clr_bits = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (irq_ack && irq_valid && (interrupt == CAUSE_W'(cause_of(s)))) clr_bits[s] = 1'b1;
    end
  end

  // Sticky pending; a set on the same edge as a clear keeps the bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else pending <= (pending & ~clr_bits) | set_bits;
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb/tb_irq_timer_ctrl.sv - self-checking bench for irq_timer_ctrl with a cause scoreboard
module tb_irq_timer_ctrl;

  localparam int N_TIMERS = 2;
  localparam int TIMER_W  = 4;
  localparam int N_EXT    = 2;
  localparam int CAUSE_W  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_TIMERS-1:0] timer_en = '0;
  logic [N_EXT-1:0]    ext_inter = '0;
  logic                cfg_wr = 1'b0;
  logic [1:0]          cfg_addr = '0;
  logic [31:0]         cfg_data = '0;
  logic                irq_ack = 1'b0;
  logic                irq_valid;
  logic [CAUSE_W-1:0]  interrupt;
  logic [N_TIMERS-1:0] timer_ovf;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  irq_timer_ctrl #(
    .N_TIMERS(N_TIMERS), .TIMER_W(TIMER_W), .N_EXT(N_EXT), .CAUSE_W(CAUSE_W)
  ) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .ext_inter(ext_inter),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .irq_ack(irq_ack),
    .irq_valid(irq_valid), .interrupt(interrupt), .timer_ovf(timer_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  // Pops expected causes in order, waits (bounded) for each, acks it, then expects idle
  task automatic drain_scoreboard(input string name);
    int exp_c;
    int waited;
    while (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
      waited = 0;
      while (!irq_valid && waited < 10) begin tick(); waited++; end
      vectors++;
      if (irq_valid !== 1'b1 || interrupt !== CAUSE_W'(exp_c)) begin
        miscompares++;
        $display("FAIL %s cause: got valid=%0b cause=%0d expected valid=1 cause=%0d",
                 name, irq_valid, interrupt, exp_c);
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
    vectors++;
    if (irq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: got valid=%0b cause=%0d expected valid=0", name, irq_valid, interrupt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({irq_valid, interrupt, timer_ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b cause=%0d ovf=%b expected all 0",
               irq_valid, interrupt, timer_ovf);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (irq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got valid=%0b expected 0", irq_valid);
    end
  endtask

  task automatic test_timer_basic;
    logic exp_ovf;
    cfg_write(2'd0, 32'd3);
    timer_en[0] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_ovf = (t % 4 == 0);
      vectors++;
      if (timer_ovf[0] !== exp_ovf) begin
        miscompares++;
        $display("FAIL basic_ovf t=%0d: got %0b expected %0b", t, timer_ovf[0], exp_ovf);
      end
      if (t == 5 || t == 9) begin
        vectors++;
        if (irq_valid !== 1'b1 || interrupt !== 4'd1) begin
          miscompares++;
          $display("FAIL basic_irq t=%0d: got valid=%0b cause=%0d expected valid=1 cause=1",
                   t, irq_valid, interrupt);
        end
      end
      if (t == 5) irq_ack = 1'b1;
      if (t == 6) begin
        irq_ack = 1'b0;
        vectors++;
        if (irq_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_ack_clear: got valid=%0b expected 0", irq_valid);
        end
      end
    end
    timer_en[0] = 1'b0;
    exp_q.push_back(1);
    drain_scoreboard("basic_rearm");
  endtask

  task automatic test_simultaneous;
    cfg_write(2'd1, 32'd0);
    timer_en[1] = 1'b1;
    tick();
    timer_en[1] = 1'b0;
    ext_inter[0] = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(3);
    tick();
    drain_scoreboard("simultaneous");
  endtask

  task automatic test_ack_collision;
    timer_en[1] = 1'b1;
    tick();
    tick();
    vectors++;
    if (irq_valid !== 1'b1 || interrupt !== 4'd2) begin
      miscompares++;
      $display("FAIL collide_pre: got valid=%0b cause=%0d expected valid=1 cause=2", irq_valid, interrupt);
    end
    irq_ack = 1'b1;
    tick();
    vectors++;
    if (irq_valid !== 1'b1 || interrupt !== 4'd2) begin
      miscompares++;
      $display("FAIL collide_set_wins: got valid=%0b cause=%0d expected valid=1 cause=2", irq_valid, interrupt);
    end
    irq_ack = 1'b0;
    timer_en[1] = 1'b0;
    tick();
    exp_q.push_back(2);
    drain_scoreboard("collide_final");
  endtask

  task automatic test_mask;
    int waited;
    cfg_write(2'd2, 32'b1110);
    timer_en[0] = 1'b1;
    waited = 0;
    do begin tick(); waited++; end while (!timer_ovf[0] && waited < 20);
    timer_en[0] = 1'b0;
    vectors++;
    if (timer_ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mask_ovf_timeout: got ovf=%0b expected 1", timer_ovf[0]);
    end
    tick(); tick();
    vectors++;
    if (irq_valid !== 1'b0 || interrupt !== 4'd0) begin
      miscompares++;
      $display("FAIL mask_hidden: got valid=%0b cause=%0d expected valid=0 cause=0", irq_valid, interrupt);
    end
    cfg_write(2'd3, 32'hF);
    vectors++;
    if (irq_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_addr_ignored: got valid=%0b expected 0", irq_valid);
    end
    cfg_write(2'd2, 32'b1111);
    vectors++;
    if (irq_valid !== 1'b1 || interrupt !== 4'd1) begin
      miscompares++;
      $display("FAIL unmask_present: got valid=%0b cause=%0d expected valid=1 cause=1", irq_valid, interrupt);
    end
    exp_q.push_back(1);
    drain_scoreboard("unmask_drain");
  endtask

  task automatic test_wrap;
    logic exp_ovf;
    cfg_write(2'd1, 32'd15);
    timer_en[1] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      vectors++;
      if (timer_ovf[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_runup t=%0d: got %0b expected 0", t, timer_ovf[1]);
      end
    end
    timer_en[1] = 1'b0;
    cfg_write(2'd1, 32'd2);
    timer_en[1] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_ovf = (t == 9);
      vectors++;
      if (timer_ovf[1] !== exp_ovf) begin
        miscompares++;
        $display("FAIL wrap_ovf t=%0d: got %0b expected %0b", t, timer_ovf[1], exp_ovf);
      end
    end
    timer_en[1] = 1'b0;
    exp_q.push_back(2);
    tick();
    drain_scoreboard("wrap_drain");
  endtask

  task automatic test_async_reset;
    int waited;
    logic exp_ovf;
    cfg_write(2'd0, 32'd2);
    timer_en[0] = 1'b1;
    waited = 0;
    while (!irq_valid && waited < 10) begin tick(); waited++; end
    vectors++;
    if (irq_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: got valid=%0b expected 1", irq_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({irq_valid, interrupt, timer_ovf} !== '0) begin
      miscompares++;
      $display("FAIL areset_immediate: got valid=%0b cause=%0d ovf=%b expected all 0",
               irq_valid, interrupt, timer_ovf);
    end
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      exp_ovf = (t == 16);
      vectors++;
      if (timer_ovf[0] !== exp_ovf) begin
        miscompares++;
        $display("FAIL areset_count t=%0d: got ovf=%0b expected %0b", t, timer_ovf[0], exp_ovf);
      end
      if (t == 1) begin
        vectors++;
        if (irq_valid !== 1'b1 || interrupt !== 4'd3) begin
          miscompares++;
          $display("FAIL held_line_event: got valid=%0b cause=%0d expected valid=1 cause=3", irq_valid, interrupt);
        end
        irq_ack = 1'b1;
      end
      if (t == 2) begin
        irq_ack = 1'b0;
        vectors++;
        if (irq_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL held_line_once: got valid=%0b expected 0", irq_valid);
        end
      end
      if (t == 17) begin
        vectors++;
        if (irq_valid !== 1'b1 || interrupt !== 4'd1) begin
          miscompares++;
          $display("FAIL areset_first_match: got valid=%0b cause=%0d expected valid=1 cause=1", irq_valid, interrupt);
        end
      end
    end
    timer_en[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer_basic();
    test_simultaneous();
    test_ack_collision();
    test_mask();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
